// File: rtl/goertzel_bin_power_if.sv
// Sample-in / power-out bundle for the single-bin Goertzel power detector.
//   sample_valid : one-cycle strobe, sample is valid this cycle (master -> slave)
//   sample       : signed input sample, DATA_W bits                (master -> slave)
//   ready        : one-cycle pulse, power has just been updated    (slave -> master)
//   power        : unsigned bin power, held until the next ready   (slave -> master)
interface goertzel_bin_power_if #(
  parameter int DATA_W = 32
);
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample;
  logic                     ready;
  logic [63:0]              power;

  modport master (output sample_valid, output sample, input ready, input power);
  modport slave  (input sample_valid, input sample, output ready, output power);
endinterface

// File: rtl/goertzel_bin_power.sv
// Single-bin Goertzel DFT power detector.
// Runs s[n] = x[n] + COEFF*s[n-1] - s[n-2] over blocks of N samples and, at the end of
// each block, publishes |X[K]|^2 = s1^2 + s2^2 - COEFF*s1*s2 (saturated to 64 bits).
// Ports:
//   clock : system clock
//   reset : synchronous, active-high; discards any partial block and clears power
//   bus   : slave side of goertzel_bin_power_if (sample_valid/sample in, ready/power out)
module goertzel_bin_power #(
  parameter int                       N      = 520,
  parameter int                       K      = 10,
  parameter int                       DATA_W = 32,
  parameter int                       COEF_W = 34,
  parameter logic signed [COEF_W-1:0] COEFF  = 34'sd2131826074,
  parameter int                       QW     = 48,
  parameter int                       PSHIFT = 0
) (
  input  logic                clock,
  input  logic                reset,
  goertzel_bin_power_if.slave bus
);
  localparam int PW = 2*QW + 4;
  localparam int MW = COEF_W + QW - 30;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (K < 0 || 2*K > N || N < 2) begin : g_param_check
    $error("goertzel_bin_power: need N >= 2 and 0 <= K <= N/2");
  end

  // Q3.30 coefficient times state, floor-shifted back to integer scale.
  function automatic logic signed [MW-1:0] coef_mul(input logic signed [QW-1:0] q);
    logic signed [COEF_W+QW-1:0] prod;
    prod = (COEF_W+QW)'(COEFF) * (COEF_W+QW)'(q);
    return MW'(prod >>> 30);
  endfunction

  // Output scaling: negative results clamp to zero, oversize results saturate.
  function automatic logic [63:0] clamp_power(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> PSHIFT;
    if (s[PW-1])
      return '0;
    else if (|s[PW-2:64])
      return '1;
    else
      return s[63:0];
  endfunction

  logic                     busy, accept, block_end;
  logic                     vld_p0, vld_p1, vld_p2;
  logic                     pvld_p0, pvld_p1, pvld_p2;
  logic [CW-1:0]            sample_cnt;
  logic signed [DATA_W-1:0] x_p0;
  logic signed [QW-1:0]     x_p1, m_p1;
  logic signed [QW-1:0]     q0, q1, q2;
  logic signed [QW-1:0]     pq1_p0, pq2_p0, pq2_p1;
  logic signed [MW-1:0]     pm_p1;
  logic signed [PW-1:0]     sq_p1, sq_p2, cross_p2;
  logic [63:0]              power_r;
  logic                     ready_r;

  // vld_p2 has no data of its own; it extends the hold-off so that a strobe is only
  // taken four or more cycles after the previous accepted one.
  assign busy      = vld_p0 | vld_p1 | vld_p2;
  assign accept    = bus.sample_valid & ~busy;
  assign q0        = x_p1 + m_p1 - q2;
  assign block_end = vld_p1 && (sample_cnt == CW'(N-1));

  assign bus.power = power_r;
  assign bus.ready = ready_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      pvld_p0    <= 1'b0;
      pvld_p1    <= 1'b0;
      pvld_p2    <= 1'b0;
      ready_r    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      vld_p0  <= accept;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      pvld_p0 <= block_end;
      pvld_p1 <= pvld_p0;
      pvld_p2 <= pvld_p1;
      ready_r <= pvld_p2;
      if (vld_p1)
        sample_cnt <= block_end ? '0 : sample_cnt + CW'(1);
    end
  end

  // Recurrence state and the published power are architecturally visible, so they
  // are cleared by reset; the block-final values are snapshotted into the power
  // pipeline on the same edge that restarts the recurrence from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      q1      <= '0;
      q2      <= '0;
      power_r <= '0;
    end else begin
      if (vld_p1) begin
        if (block_end) begin
          q1 <= '0;
          q2 <= '0;
        end else begin
          q1 <= q0;
          q2 <= q1;
        end
      end
      if (pvld_p2)
        power_r <= clamp_power(sq_p2 - cross_p2);
    end
  end

  always_ff @(posedge clock) begin
    // p0: capture accepted sample / block-final state
    if (accept)
      x_p0 <= bus.sample;
    if (block_end) begin
      pq1_p0 <= q0;
      pq2_p0 <= q1;
    end
    // p1: coefficient product for the recurrence; squares for the power
    x_p1   <= QW'(x_p0);
    m_p1   <= QW'(coef_mul(q1));
    sq_p1  <= PW'(pq1_p0) * PW'(pq1_p0) + PW'(pq2_p0) * PW'(pq2_p0);
    pm_p1  <= coef_mul(pq1_p0);
    pq2_p1 <= pq2_p0;
    // p2: cross term of the power
    sq_p2    <= sq_p1;
    cross_p2 <= PW'(pm_p1) * PW'(pq2_p1);
  end
endmodule

// File: tb/tb_goertzel_bin_power.sv
// Directed bench for goertzel_bin_power: zero block, impulse, on-bin and off-bin sines,
// block-to-block repeatability, reset mid-block (with a coincident strobe) and a
// dropped close-spaced strobe.
module tb_goertzel_bin_power;
  localparam int                N     = 520;
  localparam int                QW    = 48;
  localparam int                PW    = 2*QW + 4;
  localparam logic signed [33:0] COEFF = 34'sd2131826074;
  localparam logic [63:0]       ON_BIN_EXP = 64'd74326986037657600; // (2^20*520/2)^2

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  goertzel_bin_power_if bus ();

  goertzel_bin_power dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int ready_cnt = 0;
  int xs [N];

  always @(negedge clock) if (bus.ready === 1'b1) ready_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_range(input string tag, input logic [63:0] obs,
                             input logic [63:0] lo, input logic [63:0] hi);
    checks++;
    assert (obs >= lo && obs <= hi) passed++;
    else $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
  endtask

  // Straight-line reference of the recurrence and power formula over xs[].
  function automatic logic [63:0] model_power();
    logic signed [QW-1:0] s0, s1, s2, m;
    logic signed [81:0]   prod;
    logic signed [PW-1:0] mm, p;
    s1 = '0;
    s2 = '0;
    for (int n = 0; n < N; n++) begin
      prod = 82'(COEFF) * 82'(s1);
      m    = QW'(prod >>> 30);
      s0   = QW'(xs[n]) + m - s2;
      s2   = s1;
      s1   = s0;
    end
    prod = 82'(COEFF) * 82'(s1);
    mm   = PW'(prod >>> 30);
    p    = PW'(s1) * PW'(s1) + PW'(s2) * PW'(s2) - mm * PW'(s2);
    if (p[PW-1]) return '0;
    if (p > PW'(64'hFFFF_FFFF_FFFF_FFFF)) return '1;
    return p[63:0];
  endfunction

  task automatic fill_zero();
    for (int n = 0; n < N; n++) xs[n] = 0;
  endtask

  task automatic fill_impulse();
    for (int n = 0; n < N; n++) xs[n] = (n == 0) ? 1000 : 0;
  endtask

  task automatic fill_sine(input int period);
    for (int n = 0; n < N; n++)
      xs[n] = $rtoi($floor(1048576.0 * $sin(2.0 * 3.14159265358979 * n / period) + 0.5));
  endtask

  // One strobe, sampled on the next rising edge; returns gap cycles later at edge+1.
  task automatic send(input int x, input int gap);
    bus.sample       = x;
    bus.sample_valid = 1'b1;
    @(posedge clock); #1;
    bus.sample_valid = 1'b0;
    repeat (gap - 1) begin @(posedge clock); #1; end
  endtask

  // Sends xs[first..N-1]; checks ready latency/width and returns the published power.
  task automatic finish_block(input string tag, input int first, input int gap,
                              output logic [63:0] pw);
    int lat;
    int c0;
    c0 = ready_cnt;
    for (int n = first; n < N - 1; n++) send(xs[n], gap);
    send(xs[N-1], 1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (bus.ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    pw = bus.power;
    check({tag, "_latency"}, 64'(lat), 64'd5);
    @(posedge clock); #1;
    check({tag, "_ready_width"}, 64'(bus.ready), 64'd0);
    check({tag, "_ready_count"}, 64'(ready_cnt - c0), 64'd1);
  endtask

  logic [63:0] p, p_imp, p_on, p_ref;
  int          c_before;

  initial begin
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_power", bus.power, 64'd0);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_ready_count", 64'(ready_cnt), 64'd0);

    // All-zero block, wide spacing
    fill_zero();
    finish_block("zero", 0, 20, p);
    check("zero_power", p, 64'd0);

    // Impulse of 1000: analytic |X|^2 = 1e6; floor rounding of the coefficient product
    // adds a few LSB of noise to X, so the analytic band is wider than the exact match.
    fill_impulse();
    p_ref = model_power();
    finish_block("impulse", 0, 4, p_imp);
    check("impulse_exact", p_imp, p_ref);
    check_range("impulse_analytic", p_imp, 64'd950000, 64'd1050000);

    // On-bin sine, period 52 samples
    fill_sine(52);
    p_ref = model_power();
    finish_block("onbin", 0, 4, p_on);
    check("onbin_exact", p_on, p_ref);
    check_range("onbin_analytic", p_on, ON_BIN_EXP - ON_BIN_EXP / 100,
                ON_BIN_EXP + ON_BIN_EXP / 100);
    finish_block("onbin2", 0, 4, p);
    check("onbin_repeat", p, p_on);

    // Off-bin sine, period 26 (bin 20)
    fill_sine(26);
    p_ref = model_power();
    finish_block("offbin", 0, 4, p);
    check("offbin_exact", p, p_ref);
    check_range("offbin_leak", p, 64'd0, p_on / 1000);

    // Reset at sample 300 of an on-bin block, with a strobe on the reset cycle
    fill_sine(52);
    for (int n = 0; n < 300; n++) send(xs[n], 4);
    c_before         = ready_cnt;
    reset            = 1'b1;
    bus.sample       = 7777;
    bus.sample_valid = 1'b1;
    @(posedge clock); #1;
    reset            = 1'b0;
    bus.sample_valid = 1'b0;
    check("midreset_power", bus.power, 64'd0);
    check("midreset_ready", 64'(bus.ready), 64'd0);
    repeat (20) @(posedge clock);
    #1;
    check("midreset_no_ready", 64'(ready_cnt - c_before), 64'd0);
    finish_block("after_reset", 0, 4, p);
    check("after_reset_power", p, p_on);

    // Second strobe 2 cycles after an accepted one is dropped
    fill_impulse();
    c_before = ready_cnt;
    send(xs[0], 1);
    @(posedge clock); #1;
    bus.sample       = 5000;
    bus.sample_valid = 1'b1;
    @(posedge clock); #1;
    bus.sample_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    for (int n = 1; n < N - 1; n++) send(xs[n], 4);
    repeat (10) @(posedge clock);
    #1;
    check("drop_no_early_ready", 64'(ready_cnt - c_before), 64'd0);
    finish_block("drop", N - 1, 4, p);
    check("drop_power", p, p_imp);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
